data_mem_bank: RTL and testbench
================================

// Module: data_mem_bank
// PURPOSE
//  Parametrised CPU data memory: synchronous byte-enabled write, registered read with
//  valid strobe, address range checking, and a hardware clear sequencer. It is the
//  zero-on-reset RAM for the datapath (store from Reg_Cout path, load to writeback).
//  Array clears one word/cycle; there is no async array reset.
// PARAMETERS
//  DW     16  data width in bits; must be a multiple of 8
//  DEPTH  16  number of words; 2 <= DEPTH <= 2**AW
//  AW     5   address width in bits
// PORTS
//  clk    in   1       clock; all state changes on rising edge
//  reset  in   1       asynchronous reset, active-low
//  req    in   1       access request, sampled on rising clk
//  wen    in   1       1 = write, 0 = read (qualified by req)
//  addr   in   AW      word address
//  wdata  in   DW      write data
//  be     in   DW/8    byte enables; bit i selects wdata[8i+7:8i]
//  clr    in   1       start a full-array clear sweep (one-cycle pulse)
//  rdata  out  DW      read data, valid when rvalid=1
//  rvalid out  1       one-cycle strobe for read data
//  busy   out  1       clear sweep in progress; requests ignored
//  addr_err out 1      one-cycle strobe: accepted request had addr >= DEPTH
// BEHAVIOUR
//  Reset (reset=0): state=CLEAR, clr_ptr=0, busy=1, rvalid=0, rdata=0, addr_err=0.
//   Array contents are untouched by reset itself; the sweep zeroes them.
//  FSM states: CLEAR, IDLE.
//   CLEAR: each cycle write 0 to mem[clr_ptr], clr_ptr++. On the cycle that writes
//    DEPTH-1, go to IDLE; busy drops the next cycle. busy=1 exactly DEPTH cycles after
//    reset release.
//   IDLE: clr=1 -> CLEAR, clr_ptr=0, busy=1 next cycle. Otherwise service req.
//  Accepted request: req=1, state=IDLE, clr=0. clr has priority: req dropped that cycle.
//  While busy=1: req ignored; no write, rvalid=0, addr_err=0. clr ignored (no restart).
//  Write (wen=1, addr<DEPTH): for each i with be[i]=1, mem[addr] byte i <= wdata byte i.
//   Other bytes keep their value. be=0 is a legal no-op. rvalid stays 0.
//  Read (wen=0, addr<DEPTH): next cycle rdata=mem[addr], rvalid=1 for one cycle.
//   Latency 1. rdata holds its last value while rvalid=0.
//   Read the cycle after a write to the same address returns the new data.
//   Back-to-back reads give one result per cycle.
//  Out of range (addr >= DEPTH): write dropped, no aliasing by truncation.
//   Read returns rdata=0 with rvalid=1. addr_err=1 the next cycle for either case.
//  Reset mid-sweep: clr_ptr returns to 0, and the full DEPTH-cycle sweep reruns.
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  T1 release reset -> busy=1 for exactly 16 cycles; then read addr 3 -> rdata=0x0000, rvalid 1 cycle.
//  T2 write addr5 wdata=0xBEEF be=2'b11; next cycle read addr5 -> rdata=0xBEEF.
//  T3 write addr5 wdata=0x1234 be=2'b01 -> read addr5 = 0xBE34. Then be=2'b00 -> unchanged.
//  T4 write addr20 0xFFFF -> addr_err pulse; read addr4 stays 0; read addr20 -> rdata=0, addr_err.
//  T5 pulse clr with req read on the same cycle -> no rvalid, busy 16 cycles, req ignored;
//     afterwards read addr5 -> 0x0000.
//  T6 assert reset at clr_ptr=7 mid-sweep -> busy=1 for a full 16 cycles after release;
//     all words read 0.

Source files
------------

// File: rtl/data_mem_bank.sv
// Parametrised data memory: byte-enabled synchronous write, registered read with valid
// strobe, address range checking and a one-word-per-cycle hardware clear sequencer.
module data_mem_bank #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            wen,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  input  logic            clr,
  output logic [DW-1:0]   rdata,
  output logic            rvalid,
  output logic            busy,
  output logic            addr_err
);

  localparam int            BW       = DW / 8;
  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] clr_ptr, ptr_nxt;
  logic          clr_we;
  logic          accept;
  logic          in_range;
  logic          wr_en;
  logic          rd_en;
  logic [IW-1:0] idx;

  logic [DW-1:0] mem [DEPTH];

  // Full-width compare so out-of-range addresses never alias onto a truncated index.
  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign idx      = addr[IW-1:0];
  assign wr_en    = accept & wen & in_range;
  assign rd_en    = accept & ~wen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    clr_we    = 1'b0;
    accept    = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_ptr == LAST_PTR) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = clr_ptr + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end else begin
          accept = req;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Array has no reset; the sweep is held off while reset is asserted so reset alone leaves it intact.
  always_ff @(posedge clk) begin
    if (clr_we && reset) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < BW; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
      addr_err <= 1'b0;
    end else begin
      busy     <= (state_nxt == CLEAR);
      rvalid   <= rd_en;
      addr_err <= accept & ~in_range;
      if (rd_en) rdata <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_bank.sv
// Self-checking bench for data_mem_bank: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_data_mem_bank;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int BW    = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, wen, clr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [BW-1:0] be;
  logic [DW-1:0] rdata;
  logic          rvalid, busy, addr_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_rd;

  always #5 clk = ~clk;

  data_mem_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .be(be), .clr(clr), .rdata(rdata), .rvalid(rvalid), .busy(busy), .addr_err(addr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input int a, input logic [DW-1:0] d,
                       input logic [BW-1:0] b, input logic c);
    req = r; wen = w; addr = a[AW-1:0]; wdata = d; be = b; clr = c;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
  endtask

  function automatic void model_write(int a, logic [DW-1:0] d, logic [BW-1:0] b);
    logic [DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < BW; i++) if (b[i]) mask = mask | (DW'(8'hFF) << (8 * i));
    if (a < DEPTH) model[a] = (model[a] & ~mask) | (d & mask);
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endfunction

  task automatic test_reset();
    int cnt;
    idle_in();
    reset = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({busy, rvalid, addr_err, rdata} !== {1'b1, 1'b0, 1'b0, {DW{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b rvalid=%b addr_err=%b rdata=%h, want 1 0 0 0000",
               busy, rvalid, addr_err, rdata);
    end
    reset = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; step(); end
    n_cmp++;
    if (cnt != DEPTH) begin n_err++; $display("FAIL reset_busy_len: got %0d cycles, want %0d", cnt, DEPTH); end
    model_zero();
    drive(1'b1, 1'b0, 3, '0, '0, 1'b0);
    step();
    idle_in();
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
      n_err++; $display("FAIL t1_read3: got rvalid=%b rdata=%h, want 1 0000", rvalid, rdata);
    end
    step();
    n_cmp++;
    if (rvalid !== 1'b0) begin n_err++; $display("FAIL t1_rvalid_pulse: got %b want 0", rvalid); end
    last_rd = 16'h0000;
  endtask

  task automatic test_full_write();
    drive(1'b1, 1'b1, 5, 16'hBEEF, 2'b11, 1'b0);
    step();
    model_write(5, 16'hBEEF, 2'b11);
    n_cmp++;
    if (rvalid !== 1'b0 || addr_err !== 1'b0) begin
      n_err++; $display("FAIL t2_write_flags: got rvalid=%b addr_err=%b want 0 0", rvalid, addr_err);
    end
    drive(1'b1, 1'b0, 5, '0, '0, 1'b0);
    step();
    idle_in();
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 16'hBEEF) begin
      n_err++; $display("FAIL t2_read5: got rvalid=%b rdata=%h want 1 beef", rvalid, rdata);
    end
    step();
    n_cmp++;
    if (rdata !== 16'hBEEF || rvalid !== 1'b0) begin
      n_err++; $display("FAIL t2_rdata_hold: got rvalid=%b rdata=%h want 0 beef", rvalid, rdata);
    end
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 1'b1, 5, 16'h1234, 2'b01, 1'b0); step();
    drive(1'b1, 1'b0, 5, '0, '0, 1'b0);          step();
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 16'hBE34) begin
      n_err++; $display("FAIL t3_be01: got rvalid=%b rdata=%h want 1 be34", rvalid, rdata);
    end
    drive(1'b1, 1'b1, 5, 16'h5678, 2'b00, 1'b0); step();
    drive(1'b1, 1'b0, 5, '0, '0, 1'b0);          step();
    n_cmp++;
    if (rdata !== 16'hBE34) begin n_err++; $display("FAIL t3_be00: got %h want be34", rdata); end
    drive(1'b1, 1'b1, 5, 16'hA1C3, 2'b10, 1'b0); step();
    drive(1'b1, 1'b0, 5, '0, '0, 1'b0);          step();
    idle_in();
    n_cmp++;
    if (rdata !== 16'hA134) begin n_err++; $display("FAIL t3_be10: got %h want a134", rdata); end
    model[5] = 16'hA134;
    step();
  endtask

  task automatic test_range();
    drive(1'b1, 1'b1, 20, 16'hFFFF, 2'b11, 1'b0);
    step();
    idle_in();
    n_cmp++;
    if (addr_err !== 1'b1 || rvalid !== 1'b0) begin
      n_err++; $display("FAIL t4_wr_err: got addr_err=%b rvalid=%b want 1 0", addr_err, rvalid);
    end
    step();
    n_cmp++;
    if (addr_err !== 1'b0) begin n_err++; $display("FAIL t4_err_pulse: got %b want 0", addr_err); end
    drive(1'b1, 1'b0, 4, '0, '0, 1'b0); step();
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 16'h0000 || addr_err !== 1'b0) begin
      n_err++; $display("FAIL t4_no_alias: got rvalid=%b rdata=%h err=%b want 1 0000 0", rvalid, rdata, addr_err);
    end
    drive(1'b1, 1'b0, 5, '0, '0, 1'b0); step();
    drive(1'b1, 1'b0, 20, '0, '0, 1'b0); step();
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 16'h0000 || addr_err !== 1'b1) begin
      n_err++; $display("FAIL t4_rd_oor: got rvalid=%b rdata=%h err=%b want 1 0000 1", rvalid, rdata, addr_err);
    end
    drive(1'b1, 1'b1, DEPTH - 1, 16'h7E7E, 2'b11, 1'b0); step();
    model_write(DEPTH - 1, 16'h7E7E, 2'b11);
    drive(1'b1, 1'b0, DEPTH, '0, '0, 1'b0); step();
    n_cmp++;
    if (addr_err !== 1'b1 || rdata !== 16'h0000) begin
      n_err++; $display("FAIL t4_depth_edge: got err=%b rdata=%h want 1 0000", addr_err, rdata);
    end
    drive(1'b1, 1'b0, DEPTH - 1, '0, '0, 1'b0); step();
    idle_in();
    n_cmp++;
    if (addr_err !== 1'b0 || rdata !== model[DEPTH - 1]) begin
      n_err++; $display("FAIL t4_last_word: got err=%b rdata=%h want 0 %h", addr_err, rdata, model[DEPTH - 1]);
    end
    last_rd = rdata === model[DEPTH - 1] ? model[DEPTH - 1] : rdata;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, i, DW'($urandom), BW'($urandom), 1'b0);
      model_write(i, wdata, be);
      step();
      drive(1'b1, 1'b0, i, '0, '0, 1'b0);
      step();
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== model[i]) begin
        n_err++; $display("FAIL b2b_raw[%0d]: got rvalid=%b rdata=%h want 1 %h", i, rvalid, rdata, model[i]);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, DEPTH - 1 - i, '0, '0, 1'b0);
      step();
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== model[DEPTH - 1 - i]) begin
        n_err++; $display("FAIL b2b_rd[%0d]: got rvalid=%b rdata=%h want 1 %h",
                          DEPTH - 1 - i, rvalid, rdata, model[DEPTH - 1 - i]);
      end
    end
    idle_in();
    last_rd = model[0];
    step();
  endtask

  task automatic test_random();
    logic          r, w;
    int            a;
    logic [DW-1:0] d, exp_rd;
    logic [BW-1:0] b;
    logic          exp_rv, exp_err;
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, DEPTH - 1);
      d = DW'($urandom);
      b = BW'($urandom);
      drive(r, w, a, d, b, 1'b0);
      exp_rv  = r && !w;
      exp_err = r && (a >= DEPTH);
      exp_rd  = exp_rv ? ((a < DEPTH) ? model[a] : '0) : last_rd;
      step();
      if (r && w) model_write(a, d, b);
      last_rd = exp_rd;
      n_cmp++;
      if (rvalid !== exp_rv || addr_err !== exp_err || rdata !== exp_rd) begin
        n_err++;
        $display("FAIL rand[%0d] r=%b w=%b a=%0d: got rv=%b err=%b rd=%h want %b %b %h",
                 n, r, w, a, rvalid, addr_err, rdata, exp_rv, exp_err, exp_rd);
      end
    end
    idle_in();
    step();
  endtask

  task automatic test_clr();
    int cnt;
    drive(1'b1, 1'b1, 5, 16'hC0DE, 2'b11, 1'b0); step();
    drive(1'b1, 1'b0, 5, '0, '0, 1'b1);
    step();
    n_cmp++;
    if (rvalid !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL t5_clr_prio: got rvalid=%b busy=%b want 0 1", rvalid, busy);
    end
    cnt = 1;
    while (busy === 1'b1 && cnt < 100) begin
      drive(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), DW'($urandom), '1,
            1'($urandom_range(0, 1)));
      step();
      n_cmp++;
      if (rvalid !== 1'b0 || addr_err !== 1'b0) begin
        n_err++; $display("FAIL t5_busy_ignore: got rvalid=%b addr_err=%b want 0 0", rvalid, addr_err);
      end
      if (busy === 1'b1) cnt++;
    end
    idle_in();
    n_cmp++;
    if (cnt != DEPTH) begin n_err++; $display("FAIL t5_busy_len: got %0d cycles, want %0d", cnt, DEPTH); end
    model_zero();
    for (int i = 0; i < DEPTH; i += 5) begin
      drive(1'b1, 1'b0, i, '0, '0, 1'b0);
      step();
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
        n_err++; $display("FAIL t5_cleared[%0d]: got rvalid=%b rdata=%h want 1 0000", i, rvalid, rdata);
      end
    end
    idle_in();
    step();
  endtask

  task automatic test_reset_midsweep();
    int cnt;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, i, DW'($urandom_range(1, 16'hFFFF)), '1, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    step();
    idle_in();
    repeat (7) step();
    reset = 1'b0;
    step();
    step();
    n_cmp++;
    if (busy !== 1'b1 || rvalid !== 1'b0) begin
      n_err++; $display("FAIL t6_in_reset: got busy=%b rvalid=%b want 1 0", busy, rvalid);
    end
    reset = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; step(); end
    n_cmp++;
    if (cnt != DEPTH) begin n_err++; $display("FAIL t6_busy_len: got %0d cycles, want %0d", cnt, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, i, '0, '0, 1'b0);
      step();
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
        n_err++; $display("FAIL t6_zero[%0d]: got rvalid=%b rdata=%h want 1 0000", i, rvalid, rdata);
      end
    end
    idle_in();
    step();
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_enable();
    test_range();
    test_back_to_back();
    test_random();
    test_clr();
    test_reset_midsweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
